sevenseg_scan_ctrl: RTL and testbench
=====================================

# sevenseg_scan_ctrl

Time-multiplexing controller that shares one `vsevenseg` hex decoder across a 4-digit common-anode display. It holds a 16-bit display word, steps the decoder input `x` through the four nibbles and drives active-low digit enables. A blanking gap between digits suppresses ghosting. New values go through a load/ack handshake and are committed only at a frame boundary, so a frame never shows a mix of old and new digits. It sits between the lab's value source (switches or counter) and the decoder, whose `seg_L` goes straight to the board.

## Interface

- `REFRESH_DIV`, default 100000: clock cycles each digit is shown (SHOW slot length); legal range ≥1.
- `GAP_CYCLES`, default 2: clock cycles with all digits off between slots; legal range ≥1.
- `clk`  in  1  system clock; all state updates on rising edge.
- `rst`  in  1  reset. One clock; reset is synchronous and active-high.
- `value`  in  16  four hex nibbles; `value[3:0]` = digit 0 (rightmost).
- `load`  in  1  single-cycle strobe: capture `value` into the staging register.
- `blank_lz`  in  1  leading-zero blanking enable; level, evaluated every cycle.
- `x`  out  4  nibble presented to the `vsevenseg` decoder.
- `an_L`  out  4  active-low one-hot digit enable; `an_L[i]` = digit i.
- `pending`  out  1  staged value awaiting commit.
- `load_ack`  out  1  one-cycle pulse: staged value committed to display.

## Operation

- Registers: `disp` (16), `stage` (16), `pending`, `digit` (2), `state` ∈ {SHOW, GAP}, cycle counter `cnt`, `load_ack`.
- All outputs decode from registers only; there is no combinational path from inputs to outputs.
- SHOW:
  - `x` = `disp[4*digit+3 : 4*digit]`.
  - `an_L` = ~(1<<digit), unless the digit is blanked, in which case `an_L` = 4'b1111.
  - After `REFRESH_DIV` cycles, move to GAP.
- GAP:
  - `an_L` = 4'b1111 and `x` holds its SHOW value.
  - After `GAP_CYCLES` cycles, `digit` <= `digit`+1 (wraps 3→0) and state moves to SHOW.
- Scan order is 0,1,2,3,0,…
- Blanking:
  - Digit i (i = 1..3) is blanked when `blank_lz`=1 and `disp[15:4i]`==0.
  - Digit 0 is never blanked.
  - A zero digit below a nonzero digit is never blanked.
- Load:
  - `load`=1 in any cycle sets `stage` <= `value` and `pending` <= 1.
  - Last load wins; there is no queue.
- Commit:
  - Happens on the edge that moves GAP(digit 3) to SHOW(digit 0) with `pending`=1.
  - On that edge: `disp` <= `stage`, `pending` <= 0, `load_ack` <= 1 for exactly one cycle.
  - If `pending`=0 on that edge, `disp` is unchanged and `load_ack` stays 0.
- Load on the commit edge: the old `stage` is committed, and `stage` takes the new `value`. `pending` stays 1, so the new value commits at the next frame boundary. `load_ack` still pulses for the committed value.
- Reset (any cycle, including mid-slot or with `pending`=1) sets:
  - `disp`=0, `stage`=0, `pending`=0, `load_ack`=0
  - `digit`=0, state=SHOW, `cnt`=0
  - The staged value is discarded.

## Timing

- Output values while in reset and in the first cycle after reset: `x`=4'h0, `an_L`=4'b1110, `pending`=0, `load_ack`=0.
- Slot period = `REFRESH_DIV`+`GAP_CYCLES`. Frame = 4×slot period; frame boundary at cycle k·frame after reset release.
- `pending` rises the cycle after `load` is sampled.
- Commit latency, from the `load` cycle to `disp` showing the new value: 1 to frame cycles.
- `load_ack` is high during the first SHOW cycle of digit 0 after a commit.
- Changing `blank_lz` affects `an_L` in the next cycle; it never affects `x`.

## Test plan

All scenarios use `REFRESH_DIV`=4, `GAP_CYCLES`=1, so one slot = 5 cycles and one frame = 20 cycles.

1. Reset release with no load:
   - `an_L` sequence: 1110×4, 1111×1, 1101×4, 1111, 1011×4, 1111, 0111×4, 1111, then repeats.
   - `x`=0 throughout.
2. `load` with `value`=16'h1234 at cycle 3:
   - `pending`=1 from cycle 4.
   - At cycle 20: `load_ack`=1 for one cycle and `pending`=0.
   - `x` per slot: 4, 3, 2, 1.
   - Frame 0 still shows all zeros.
3. Loads of 16'hAAAA at cycle 5 then 16'h00F0 at cycle 6:
   - Exactly one `load_ack`, at cycle 20.
   - Displayed nibbles: 0, F, 0, 0.
4. `blank_lz`=1:
   - `disp`=16'h0005: digits 1–3 `an_L`=1111; digit 0 shows 5.
   - `disp`=16'h0000: only digit 0 lit, showing 0.
   - `disp`=16'h0500: digit 3 blanked; digits 2, 1, 0 lit.
5. `load` with 16'hBEEF on the cycle before the commit edge of a frame already pending 16'h1111:
   - 16'h1111 is committed with an ack.
   - `pending` stays 1.
   - 16'hBEEF is committed with an ack one frame later.
6. `rst` asserted mid-SHOW of digit 2 with `pending`=1:
   - Next cycle: `an_L`=1110, `x`=0, `pending`=0.
   - No `load_ack` follows at the next frame boundary.

Source files
------------

// File: rtl/sevenseg_scan_ctrl.sv
// sevenseg_scan_ctrl: scans a 16-bit word across a 4-digit common-anode
// display through one shared hex decoder. Each digit slot has a SHOW phase
// and a blanking GAP. New values are staged and committed only at the frame
// boundary.
module sevenseg_scan_ctrl #(
    parameter int unsigned REFRESH_DIV = 100000,
    parameter int unsigned GAP_CYCLES  = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] value,
    input  logic        load,
    input  logic        blank_lz,
    output logic [3:0]  x,
    output logic [3:0]  an_L,
    output logic        pending,
    output logic        load_ack
);

    localparam int unsigned CNT_MAX = (REFRESH_DIV > GAP_CYCLES) ? REFRESH_DIV : GAP_CYCLES;
    localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    localparam logic [CNT_W-1:0] SHOW_LAST = CNT_W'(REFRESH_DIV - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYCLES - 1);

    typedef enum logic {
        SHOW = 1'b0,
        GAP  = 1'b1
    } state_t;

    state_t           state, state_n;
    logic [1:0]       digit, digit_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [15:0]      disp, disp_n;
    logic [15:0]      stage, stage_n;
    logic             pending_n;
    logic             load_ack_n;
    logic             commit;
    logic             blank_n;
    logic [3:0]       x_n;
    logic [3:0]       an_n;
    logic [3:0]       one_hot_n;

    // Slot sequencing: SHOW for REFRESH_DIV cycles, GAP for GAP_CYCLES, then next digit.
    always_comb begin
        state_n = state;
        digit_n = digit;
        cnt_n   = cnt + CNT_W'(1);
        commit  = 1'b0;
        case (state)
            SHOW: begin
                if (cnt == SHOW_LAST) begin
                    state_n = GAP;
                    cnt_n   = '0;
                end
            end
            GAP: begin
                if (cnt == GAP_LAST) begin
                    state_n = SHOW;
                    cnt_n   = '0;
                    digit_n = digit + 2'd1;
                    // Frame boundary: leaving the gap after digit 3.
                    commit  = (digit == 2'd3) && pending;
                end
            end
            default: begin
                state_n = SHOW;
                cnt_n   = '0;
            end
        endcase
    end

    // Staging/commit datapath: last load wins, commit swaps the frame atomically.
    always_comb begin
        disp_n     = commit ? stage : disp;
        stage_n    = load ? value : stage;
        pending_n  = load ? 1'b1 : (commit ? 1'b0 : pending);
        load_ack_n = commit;
    end

    // Output decode for the coming cycle, so x/an_L are plain flops.
    always_comb begin
        blank_n = 1'b0;
        x_n     = disp_n[3:0];
        case (digit_n)
            2'd0: begin
                blank_n = 1'b0;
                x_n     = disp_n[3:0];
            end
            2'd1: begin
                blank_n = blank_lz && (disp_n[15:4] == 12'h000);
                x_n     = disp_n[7:4];
            end
            2'd2: begin
                blank_n = blank_lz && (disp_n[15:8] == 8'h00);
                x_n     = disp_n[11:8];
            end
            2'd3: begin
                blank_n = blank_lz && (disp_n[15:12] == 4'h0);
                x_n     = disp_n[15:12];
            end
            default: begin
                blank_n = 1'b0;
                x_n     = disp_n[3:0];
            end
        endcase
        one_hot_n = 4'b0001 << digit_n;
        an_n      = 4'b1111;
        if ((state_n == SHOW) && !blank_n) begin
            an_n = ~one_hot_n;
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= SHOW;
            digit    <= 2'd0;
            cnt      <= '0;
            disp     <= 16'h0000;
            stage    <= 16'h0000;
            pending  <= 1'b0;
            load_ack <= 1'b0;
            x        <= 4'h0;
            an_L     <= 4'b1110;
        end else begin
            state    <= state_n;
            digit    <= digit_n;
            cnt      <= cnt_n;
            disp     <= disp_n;
            stage    <= stage_n;
            pending  <= pending_n;
            load_ack <= load_ack_n;
            x        <= x_n;
            an_L     <= an_n;
        end
    end

endmodule

// File: tb/tb_sevenseg_scan_ctrl.sv
// Bench for sevenseg_scan_ctrl with REFRESH_DIV=4, GAP_CYCLES=1
// (slot = 5 cycles, frame = 20 cycles). Cycle 0 is the first cycle after
// the reset edge.
module tb_sevenseg_scan_ctrl;

    logic        clk;
    logic        rst;
    logic [15:0] value;
    logic        load;
    logic        blank_lz;
    logic [3:0]  x;
    logic [3:0]  an_L;
    logic        pending;
    logic        load_ack;

    int cyc;
    int tests;
    int fails;

    typedef struct {
        int         cyc;
        logic [3:0] x;
        logic [3:0] an;
        logic       p;
        logic       a;
    } exp_t;

    exp_t sb[$];

    sevenseg_scan_ctrl #(
        .REFRESH_DIV(4),
        .GAP_CYCLES (1)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .value   (value),
        .load    (load),
        .blank_lz(blank_lz),
        .x       (x),
        .an_L    (an_L),
        .pending (pending),
        .load_ack(load_ack)
    );

    // Clock generation.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Cycle index relative to the last reset edge.
    always @(posedge clk) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    // Expected response for cycle c: 'shown' is the word on display, 'lit' marks unblanked digits.
    function automatic void push_std(int c, logic [15:0] shown, logic [3:0] lit, logic p, logic a);
        exp_t       e;
        int         slot;
        logic [3:0] oh;
        slot = (c % 20) / 5;
        oh   = 4'b0001 << slot;
        e.cyc = c;
        e.x   = shown[slot*4 +: 4];
        e.an  = ((c % 5) == 4 || !lit[slot]) ? 4'b1111 : ~oh;
        e.p   = p;
        e.a   = a;
        sb.push_back(e);
    endfunction

    task automatic chk(string nm, int c, int act, int want);
        tests++;
        if (act != want) begin
            fails++;
            $display("FAIL %s cyc=%0d got=%0h want=%0h", nm, c, act, want);
        end
    endtask

    // Monitor: pops the entry for the current cycle and compares all outputs.
    always @(negedge clk) begin
        if (!rst) begin
            while (sb.size() > 0 && sb[0].cyc < cyc) begin
                tests++;
                fails++;
                $display("FAIL missed_check cyc=%0d got=none want=%0d", cyc, sb[0].cyc);
                void'(sb.pop_front());
            end
            if (sb.size() > 0 && sb[0].cyc == cyc) begin
                exp_t e;
                e = sb.pop_front();
                chk("x", cyc, int'(x), int'(e.x));
                chk("an_L", cyc, int'(an_L), int'(e.an));
                chk("pending", cyc, int'(pending), int'(e.p));
                chk("load_ack", cyc, int'(load_ack), int'(e.a));
            end
        end
    end

    task automatic wait_cyc(int c);
        int g;
        g = 0;
        while (cyc != c) begin
            @(posedge clk);
            #1;
            g++;
            if (g > 5000) begin
                $display("FAIL wait_cyc got=%0d want=%0d", cyc, c);
                $fatal(1, "cycle wait expired");
            end
        end
    endtask

    task automatic do_load(int c, logic [15:0] v);
        wait_cyc(c);
        value = v;
        load  = 1'b1;
        @(posedge clk);
        #1;
        load = 1'b0;
    endtask

    // Leaves rst high across one edge; caller pushes expectations then drops rst.
    task automatic reset_start();
        rst  = 1'b1;
        load = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (sb.size() != 0) begin
            tests++;
            fails++;
            $display("FAIL drain_timeout got=%0d want=0 entries left", sb.size());
            sb.delete();
        end
    endtask

    initial begin
        tests    = 0;
        fails    = 0;
        rst      = 1'b1;
        value    = 16'h0000;
        load     = 1'b0;
        blank_lz = 1'b0;

        // 1: free-running scan after reset, display all zeros.
        reset_start();
        for (int c = 0; c < 40; c++) push_std(c, 16'h0000, 4'hF, 1'b0, 1'b0);
        rst = 1'b0;
        wait_drain();

        // 2: single load at cycle 3, commit at frame boundary (cycle 20).
        reset_start();
        for (int c = 0; c < 40; c++)
            push_std(c, (c < 20) ? 16'h0000 : 16'h1234, 4'hF, (c >= 4 && c < 20), (c == 20));
        rst = 1'b0;
        do_load(3, 16'h1234);
        wait_drain();

        // 3: back-to-back loads, last one wins, one ack.
        reset_start();
        for (int c = 0; c < 46; c++)
            push_std(c, (c < 20) ? 16'h0000 : 16'h00F0, 4'hF, (c >= 6 && c < 20), (c == 20));
        rst = 1'b0;
        do_load(5, 16'hAAAA);
        do_load(6, 16'h00F0);
        wait_drain();

        // 4: leading-zero blanking with 0000, 0005, 0500, then blanking released.
        reset_start();
        blank_lz = 1'b1;
        for (int c = 0; c < 20; c++) push_std(c, 16'h0000, 4'h1, (c >= 1), 1'b0);
        for (int c = 20; c < 40; c++) push_std(c, 16'h0005, 4'h1, (c >= 21), (c == 20));
        for (int c = 40; c < 60; c++) push_std(c, 16'h0500, (c >= 58) ? 4'hF : 4'h7, 1'b0, (c == 40));
        for (int c = 60; c < 63; c++) push_std(c, 16'h0500, 4'hF, 1'b0, 1'b0);
        rst = 1'b0;
        do_load(0, 16'h0005);
        do_load(20, 16'h0500);
        wait_cyc(57);
        blank_lz = 1'b0;
        wait_drain();

        // 5: load on the commit edge keeps pending; second value commits next frame.
        reset_start();
        for (int c = 0; c < 60; c++)
            push_std(c, (c < 20) ? 16'h0000 : ((c < 40) ? 16'h1111 : 16'hBEEF), 4'hF,
                     (c >= 3 && c < 40), (c == 20 || c == 40));
        rst = 1'b0;
        do_load(2, 16'h1111);
        do_load(19, 16'hBEEF);
        wait_drain();

        // 6: reset mid-SHOW of digit 2 discards the staged value.
        reset_start();
        for (int c = 0; c < 12; c++) push_std(c, 16'h0000, 4'hF, (c >= 3), 1'b0);
        rst = 1'b0;
        do_load(2, 16'h1234);
        wait_cyc(12);
        rst = 1'b1;
        @(posedge clk);
        #1;
        for (int c = 0; c < 26; c++) push_std(c, 16'h0000, 4'hF, 1'b0, 1'b0);
        rst = 1'b0;
        wait_drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // Global time limit.
    initial begin
        #200000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
